credit_sender: RTL and testbench

CREDIT_SENDER -- requirements
Module: credit_sender

---
 rtl/credit_pkg.sv | 22 ++
 rtl/credit_sender_counter.sv | 78 +++++++
 rtl/credit_sender.sv | 120 ++++++++++++
 tb/tb_credit_sender.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/credit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : credit_pkg
// Description : Shared definitions for the credit sender block: sender state
//               encoding and default payload / credit-ceiling constants.
// Revision    : 1.0 - initial release
// ============================================================================
package credit_pkg;

    // Default payload width and credit ceiling used by credit_sender.
    localparam int CREDIT_DATA_WIDTH_DEFAULT  = 8;
    localparam int CREDIT_MAX_CREDITS_DEFAULT = 8;

    // Sender link-state encoding.
    typedef enum logic [1:0] {
        SENDER_RESET  = 2'd0,
        SENDER_WAIT   = 2'd1,
        SENDER_ACTIVE = 2'd2
    } sender_state_t;

endpackage : credit_pkg
`default_nettype wire

// File: rtl/credit_sender_counter.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender_counter
// Description : Credit bookkeeping for credit_sender. Holds the credit count,
//               loads the initial credit value, applies send/return updates
//               with saturation at MAX_CREDITS, and derives the credits that
//               are usable after the withheld amount is removed.
// Ports       : clk, rst (async active-low)
//               i_load / i_load_value : force count to the initial value
//               i_dec                 : one credit consumed by a transfer
//               i_inc                 : one credit returned (already qualified)
//               i_withhold            : credits held back from use
//               o_count / o_available : current and usable credits
//               o_error               : sticky overflow flag
// Config      : CREDIT_SENDER_OVERFLOW_CHECK_EN - when defined, a sticky
//               overflow flop drives o_error; otherwise o_error is tied 0.
// Revision    : 1.0 - initial release
// ============================================================================
module credit_sender_counter #(
    parameter  int MAX_CREDITS = 8,
    localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_value,
    input  logic          i_dec,
    input  logic          i_inc,
    input  logic [CW-1:0] i_withhold,
    output logic [CW-1:0] o_count,
    output logic [CW-1:0] o_available,
    output logic          o_error
);

    localparam logic [CW-1:0] c_max = CW'(MAX_CREDITS);

    logic [CW-1:0] r_count;

    // A simultaneous send and return cancel out, so only the unpaired cases
    // move the count. A lone return at the ceiling is dropped (saturation).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_dec && !i_inc) begin
            r_count <= r_count - CW'(1);
        end else if (i_inc && !i_dec && (r_count != c_max)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_count     = r_count;
    assign o_available = (r_count > i_withhold) ? (r_count - i_withhold) : '0;

`ifdef CREDIT_SENDER_OVERFLOW_CHECK_EN
    logic w_overflow;
    logic r_error;

    // Overflow is a return the counter had to discard. Loading is excluded
    // because returns are never accepted while the count is being loaded.
    assign w_overflow = i_inc && !i_dec && !i_load && (r_count == c_max);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_error <= 1'b0;
        end else if (w_overflow) begin
            r_error <= 1'b1;
        end
    end

    assign o_error = r_error;
`else
    assign o_error = 1'b0;
`endif

endmodule : credit_sender_counter
`default_nettype wire

// File: rtl/credit_sender.sv
`default_nettype none
// ============================================================================
// Module      : credit_sender
// Description : Credit-based sender. Accepts payloads from upstream while
//               usable credits remain, forwards them through a one-cycle
//               output register, and tracks credits returned by the receiver.
//               A small link FSM (RESET -> WAIT -> ACTIVE) handles the reset
//               handshake with the receiver.
// Ports       : clk, rst (async active-low)
//               push_valid/push_ready/push_data : upstream handshake
//               pop_valid/pop_data              : registered output
//               pop_credit/pop_credit_stall     : credit return path
//               pop_sender_in_reset / pop_receiver_in_reset : link reset
//               credit_initial/credit_withhold  : credit configuration
//               credit_count/credit_available/credit_error : status
// Config      : CREDIT_SENDER_OVERFLOW_CHECK_EN - enables the sticky
//               credit_error flag (see credit_sender_counter).
// Revision    : 1.0 - initial release
// ============================================================================
module credit_sender
    import credit_pkg::*;
#(
    parameter  int DATA_WIDTH  = CREDIT_DATA_WIDTH_DEFAULT,
    parameter  int MAX_CREDITS = CREDIT_MAX_CREDITS_DEFAULT,
    localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_valid,
    output logic                  push_ready,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop_credit,
    output logic                  pop_credit_stall,
    output logic                  pop_sender_in_reset,
    input  logic                  pop_receiver_in_reset,
    input  logic [CW-1:0]         credit_initial,
    input  logic [CW-1:0]         credit_withhold,
    output logic [CW-1:0]         credit_count,
    output logic [CW-1:0]         credit_available,
    output logic                  credit_error
);

    localparam logic [1:0] S_RESET  = SENDER_RESET;
    localparam logic [1:0] S_WAIT   = SENDER_WAIT;
    localparam logic [1:0] S_ACTIVE = SENDER_ACTIVE;

    logic [1:0]            r_state;
    logic                  r_pop_valid;
    logic [DATA_WIDTH-1:0] r_pop_data;

    logic w_active;
    logic w_wait;
    logic w_transfer;
    logic w_credit_accept;

    assign w_active        = (r_state == S_ACTIVE);
    assign w_wait          = (r_state == S_WAIT);
    assign push_ready      = w_active && (credit_available != '0);
    assign w_transfer      = push_valid && push_ready;
    // Credit returns only count while the link is up; the stall output tells
    // the receiver so it can hold them.
    assign w_credit_accept = pop_credit && w_active;

    // ------------------------------------------------------------------------
    // Link FSM. S_RESET is held by the async reset and lasts one clock after
    // release; S_WAIT waits for the receiver to leave its own reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_RESET;
        end else begin
            case (r_state)
                S_RESET:  r_state <= S_WAIT;
                S_WAIT:   if (!pop_receiver_in_reset) r_state <= S_ACTIVE;
                S_ACTIVE: if (pop_receiver_in_reset)  r_state <= S_WAIT;
                default:  r_state <= S_RESET;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output register. Valid is a one-cycle pulse per transfer; data holds
    // between transfers. A receiver reset drops any pending valid.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pop_valid <= 1'b0;
            r_pop_data  <= '0;
        end else begin
            r_pop_valid <= w_transfer && !(w_active && pop_receiver_in_reset);
            if (w_transfer) begin
                r_pop_data <= push_data;
            end
        end
    end

    assign pop_valid           = r_pop_valid;
    assign pop_data            = r_pop_data;
    assign pop_credit_stall    = !w_active;
    assign pop_sender_in_reset = (r_state == S_RESET);

    credit_sender_counter #(
        .MAX_CREDITS (MAX_CREDITS)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_wait),
        .i_load_value (credit_initial),
        .i_dec        (w_transfer),
        .i_inc        (w_credit_accept),
        .i_withhold   (credit_withhold),
        .o_count      (credit_count),
        .o_available  (credit_available),
        .o_error      (credit_error)
    );

endmodule : credit_sender
`default_nettype wire

// File: tb/tb_credit_sender.sv
`default_nettype none
// ============================================================================
// Module      : tb_credit_sender
// Description : Directed self-checking bench for credit_sender with default
//               parameters (DATA_WIDTH=8, MAX_CREDITS=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_sender;

    localparam int DW = 8;
    localparam int CW = 4;

`ifdef CREDIT_SENDER_OVERFLOW_CHECK_EN
    localparam logic c_err_exp = 1'b1;
`else
    localparam logic c_err_exp = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          push_valid;
    logic          push_ready;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_credit;
    logic          pop_credit_stall;
    logic          pop_sender_in_reset;
    logic          pop_receiver_in_reset;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic [CW-1:0] credit_available;
    logic          credit_error;

    int errors = 0;
    int checks = 0;

    credit_sender dut (
        .clk                   (clk),
        .rst                   (rst),
        .push_valid            (push_valid),
        .push_ready            (push_ready),
        .push_data             (push_data),
        .pop_valid             (pop_valid),
        .pop_data              (pop_data),
        .pop_credit            (pop_credit),
        .pop_credit_stall      (pop_credit_stall),
        .pop_sender_in_reset   (pop_sender_in_reset),
        .pop_receiver_in_reset (pop_receiver_in_reset),
        .credit_initial        (credit_initial),
        .credit_withhold       (credit_withhold),
        .credit_count          (credit_count),
        .credit_available      (credit_available),
        .credit_error          (credit_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rst_pop_valid got=%b exp=0", pop_valid); end
        checks++; if (pop_data !== 8'h00) begin errors++; $display("FAIL rst_pop_data got=%h exp=00", pop_data); end
        checks++; if (credit_count !== 4'd0) begin errors++; $display("FAIL rst_count got=%0d exp=0", credit_count); end
        checks++; if (credit_error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b exp=0", credit_error); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL rst_push_ready got=%b exp=0", push_ready); end
        checks++; if (pop_credit_stall !== 1'b1) begin errors++; $display("FAIL rst_stall got=%b exp=1", pop_credit_stall); end
        checks++; if (pop_sender_in_reset !== 1'b1) begin errors++; $display("FAIL rst_sender_in_reset got=%b exp=1", pop_sender_in_reset); end
        // Release: one clock in S_RESET, one in S_WAIT, then S_ACTIVE.
        rst = 1'b1;
        #1;
        checks++; if (pop_sender_in_reset !== 1'b1) begin errors++; $display("FAIL rel_sender_in_reset got=%b exp=1", pop_sender_in_reset); end
        tick();
        checks++; if (pop_sender_in_reset !== 1'b0) begin errors++; $display("FAIL wait_sender_in_reset got=%b exp=0", pop_sender_in_reset); end
        checks++; if (pop_credit_stall !== 1'b1) begin errors++; $display("FAIL wait_stall got=%b exp=1", pop_credit_stall); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL wait_push_ready got=%b exp=0", push_ready); end
        tick();
        checks++; if (pop_credit_stall !== 1'b0) begin errors++; $display("FAIL active_stall got=%b exp=0", pop_credit_stall); end
        checks++; if (credit_count !== 4'd2) begin errors++; $display("FAIL active_count got=%0d exp=2", credit_count); end
        checks++; if (credit_available !== 4'd2) begin errors++; $display("FAIL active_available got=%0d exp=2", credit_available); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL active_push_ready got=%b exp=1", push_ready); end
    endtask

    task automatic test_drain();
        logic [DW-1:0] data_seq [4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        logic          exp_valid [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] exp_data [4]  = '{8'hA1, 8'hA2, 8'hA2, 8'hA2};
        logic [CW-1:0] exp_count [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        int xfers = 0;
        push_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_data = data_seq[i];
            #1;
            if (push_valid && push_ready) xfers++;
            tick();
            checks++; if (pop_valid !== exp_valid[i]) begin errors++; $display("FAIL drain_valid[%0d] got=%b exp=%b", i, pop_valid, exp_valid[i]); end
            checks++; if (pop_data !== exp_data[i]) begin errors++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, pop_data, exp_data[i]); end
            checks++; if (credit_count !== exp_count[i]) begin errors++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, credit_count, exp_count[i]); end
        end
        checks++; if (xfers != 2) begin errors++; $display("FAIL drain_transfers got=%0d exp=2", xfers); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL drain_push_ready got=%b exp=0", push_ready); end
        push_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        pop_credit = 1'b1;
        tick();
        pop_credit = 1'b0;
        checks++; if (credit_count !== 4'd1) begin errors++; $display("FAIL b2b_return got=%0d exp=1", credit_count); end
        push_valid = 1'b1;
        push_data  = 8'h5A;
        pop_credit = 1'b1;
        tick();
        push_valid = 1'b0;
        pop_credit = 1'b0;
        checks++; if (credit_count !== 4'd1) begin errors++; $display("FAIL b2b_count got=%0d exp=1", credit_count); end
        checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", pop_valid); end
        checks++; if (pop_data !== 8'h5A) begin errors++; $display("FAIL b2b_data got=%h exp=5a", pop_data); end
        tick();
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got=%b exp=0", pop_valid); end
        checks++; if (pop_data !== 8'h5A) begin errors++; $display("FAIL b2b_data_hold got=%h exp=5a", pop_data); end
    endtask

    task automatic test_withhold();
        pop_credit = 1'b1;
        tick();
        tick();
        pop_credit = 1'b0;
        checks++; if (credit_count !== 4'd3) begin errors++; $display("FAIL wh_count got=%0d exp=3", credit_count); end
        credit_withhold = 4'd3;
        #1;
        checks++; if (credit_available !== 4'd0) begin errors++; $display("FAIL wh_eq_available got=%0d exp=0", credit_available); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL wh_eq_push_ready got=%b exp=0", push_ready); end
        credit_withhold = 4'd1;
        #1;
        checks++; if (credit_available !== 4'd2) begin errors++; $display("FAIL wh_1_available got=%0d exp=2", credit_available); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL wh_1_push_ready got=%b exp=1", push_ready); end
        credit_withhold = 4'd4;
        #1;
        checks++; if (credit_available !== 4'd0) begin errors++; $display("FAIL wh_gt_available got=%0d exp=0", credit_available); end
        credit_withhold = 4'd0;
        #1;
        checks++; if (credit_available !== 4'd3) begin errors++; $display("FAIL wh_0_available got=%0d exp=3", credit_available); end
    endtask

    task automatic test_receiver_reset();
        credit_initial = 4'd4;
        pop_credit = 1'b1;
        tick();
        tick();
        pop_credit = 1'b0;
        checks++; if (credit_count !== 4'd5) begin errors++; $display("FAIL rr_count_pre got=%0d exp=5", credit_count); end
        push_valid = 1'b1;
        push_data  = 8'hC3;
        pop_credit = 1'b1;
        tick();
        push_valid = 1'b0;
        pop_credit = 1'b0;
        checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL rr_valid_pre got=%b exp=1", pop_valid); end
        pop_receiver_in_reset = 1'b1;
        tick();
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL rr_valid got=%b exp=0", pop_valid); end
        checks++; if (pop_credit_stall !== 1'b1) begin errors++; $display("FAIL rr_stall got=%b exp=1", pop_credit_stall); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL rr_push_ready got=%b exp=0", push_ready); end
        pop_credit = 1'b1;
        tick();
        checks++; if (credit_count !== 4'd4) begin errors++; $display("FAIL rr_count_wait got=%0d exp=4", credit_count); end
        checks++; if (pop_credit_stall !== 1'b1) begin errors++; $display("FAIL rr_stall_wait got=%b exp=1", pop_credit_stall); end
        pop_receiver_in_reset = 1'b0;
        tick();
        pop_credit = 1'b0;
        checks++; if (credit_count !== 4'd4) begin errors++; $display("FAIL rr_count_active got=%0d exp=4", credit_count); end
        checks++; if (pop_credit_stall !== 1'b0) begin errors++; $display("FAIL rr_stall_active got=%b exp=0", pop_credit_stall); end
    endtask

    task automatic test_overflow();
        pop_credit = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (credit_count !== 4'd8) begin errors++; $display("FAIL ov_count_full got=%0d exp=8", credit_count); end
        checks++; if (credit_error !== 1'b0) begin errors++; $display("FAIL ov_error_full got=%b exp=0", credit_error); end
        tick();
        pop_credit = 1'b0;
        checks++; if (credit_count !== 4'd8) begin errors++; $display("FAIL ov_count_sat got=%0d exp=8", credit_count); end
        checks++; if (credit_error !== c_err_exp) begin errors++; $display("FAIL ov_error got=%b exp=%b", credit_error, c_err_exp); end
        tick();
        checks++; if (credit_error !== c_err_exp) begin errors++; $display("FAIL ov_error_sticky got=%b exp=%b", credit_error, c_err_exp); end
        checks++; if (credit_count !== 4'd8) begin errors++; $display("FAIL ov_count_hold got=%0d exp=8", credit_count); end
    endtask

    task automatic test_async_reset();
        push_valid = 1'b1;
        push_data  = 8'h3C;
        tick();
        push_valid = 1'b0;
        checks++; if (pop_valid !== 1'b1) begin errors++; $display("FAIL ar_valid_pre got=%b exp=1", pop_valid); end
        checks++; if (credit_count !== 4'd7) begin errors++; $display("FAIL ar_count_pre got=%0d exp=7", credit_count); end
        #2 rst = 1'b0;
        #1;
        checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b exp=0", pop_valid); end
        checks++; if (pop_data !== 8'h00) begin errors++; $display("FAIL ar_data got=%h exp=00", pop_data); end
        checks++; if (credit_count !== 4'd0) begin errors++; $display("FAIL ar_count got=%0d exp=0", credit_count); end
        checks++; if (credit_error !== 1'b0) begin errors++; $display("FAIL ar_error got=%b exp=0", credit_error); end
        checks++; if (pop_sender_in_reset !== 1'b1) begin errors++; $display("FAIL ar_sender_in_reset got=%b exp=1", pop_sender_in_reset); end
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL ar_push_ready got=%b exp=0", push_ready); end
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (credit_count !== 4'd4) begin errors++; $display("FAIL ar_count_reload got=%0d exp=4", credit_count); end
        checks++; if (pop_credit_stall !== 1'b0) begin errors++; $display("FAIL ar_stall_reload got=%b exp=0", pop_credit_stall); end
    endtask

    initial begin
        rst                   = 1'b0;
        push_valid            = 1'b0;
        push_data             = '0;
        pop_credit            = 1'b0;
        pop_receiver_in_reset = 1'b0;
        credit_initial        = 4'd2;
        credit_withhold       = 4'd0;

        test_reset();
        test_drain();
        test_back_to_back();
        test_withhold();
        test_receiver_reset();
        test_overflow();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_credit_sender
`default_nettype wire
